operand_deserializer: RTL and testbench

- Bit-serial front end for the size-exploration arithmetic units (FMA, MULT, ADDER).
- Shifts two operands in on one-bit lanes under an explicit start/strobe framing and holds the assembled pair stable.
- Presents the pair to the downstream unit through a valid/ready handshake.
- Replaces the free-running per-pin shift registers so operand boundaries are well defined and overruns are reported.

---
 rtl/operand_pkg.sv | 14 +
 rtl/serial_lane.sv | 46 ++++
 rtl/operand_deserializer.sv | 157 +++++++++++++++
 tb/tb_operand_deserializer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
// Shared types and sizing for the operand deserializer slice.
package operand_pkg;

  localparam int MAX_WIDTH = 32;
  localparam int CNT_W     = $clog2(MAX_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage : operand_pkg

// File: rtl/serial_lane.sv
// One serial lane: shift register honouring MSB_FIRST plus an optional running-parity flop.
module serial_lane #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic             parity
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] data_n;

  // A load starts a fresh frame, so the incoming bit shifts into an all-zero register.
  always_comb begin
    base = load ? '0 : data;
    if (MSB_FIRST) data_n = (base << 1) | WIDTH'(bit_in);
    else           data_n = (base >> 1) | (WIDTH'(bit_in) << (WIDTH - 1));
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset || clear)     data <= '0;
    else if (load || shift) data <= data_n;
  end

  generate
    if (PARITY_EN) begin : g_par
      always_ff @(posedge clk) begin
        if (reset || clear) parity <= 1'b0;
        else if (load)      parity <= bit_in;
        else if (shift)     parity <= parity ^ bit_in;
      end
    end else begin : g_no_par
      assign parity = 1'b0;
    end
  endgenerate

endmodule : serial_lane

// File: rtl/operand_deserializer.sv
// Framed bit-serial front end assembling an operand pair for the arithmetic units.
// Optional even-parity check per lane is enabled by defining OPERAND_PARITY_EN.
module operand_deserializer
  import operand_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic             s_start,
  input  logic             s_a,
  input  logic             s_b,
  output logic [WIDTH-1:0] ina,
  output logic [WIDTH-1:0] inb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err
);

`ifdef OPERAND_PARITY_EN
  localparam bit     PAR_EN  = 1'b1;
  localparam state_t DONE_ST = PARITY;
`else
  localparam bit     PAR_EN  = 1'b0;
  localparam state_t DONE_ST = HOLD;
`endif
  localparam state_t           FIRST_ST = (WIDTH == 1) ? DONE_ST : SHIFT;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             load, shift, clear, err_n;
  logic             par_a, par_b;
  logic             start_strobe;

  assign start_strobe = s_valid && s_start;
  assign cnt_inc      = cnt + CNT_ONE;

  serial_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST), .PARITY_EN(PAR_EN)) u_lane_a (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .load   (load),
    .shift  (shift),
    .bit_in (s_a),
    .data   (ina),
    .parity (par_a)
  );

  serial_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST), .PARITY_EN(PAR_EN)) u_lane_b (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .load   (load),
    .shift  (shift),
    .bit_in (s_b),
    .data   (inb),
    .parity (par_b)
  );

`ifndef OPERAND_PARITY_EN
  logic unused_parity;
  assign unused_parity = par_a ^ par_b;
`endif

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    shift   = 1'b0;
    clear   = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start_strobe) begin
          load    = 1'b1;
          cnt_n   = CNT_ONE;
          state_n = FIRST_ST;
        end
      end
      SHIFT: begin
        if (start_strobe) begin
          err_n   = 1'b1;
          load    = 1'b1;
          cnt_n   = CNT_ONE;
          state_n = FIRST_ST;
        end else if (s_valid) begin
          shift = 1'b1;
          cnt_n = cnt_inc;
          if (cnt_inc == CNT_LAST) state_n = DONE_ST;
        end
      end
`ifdef OPERAND_PARITY_EN
      PARITY: begin
        if (start_strobe) begin
          err_n   = 1'b1;
          load    = 1'b1;
          cnt_n   = CNT_ONE;
          state_n = FIRST_ST;
        end else if (s_valid) begin
          // Even parity: the parity bit must equal the XOR of the data bits.
          if ((s_a == par_a) && (s_b == par_b)) begin
            state_n = HOLD;
          end else begin
            err_n   = 1'b1;
            clear   = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
      end
`endif
      HOLD: begin
        if (out_ready) begin
          if (start_strobe) begin
            load    = 1'b1;
            cnt_n   = CNT_ONE;
            state_n = FIRST_ST;
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end else if (start_strobe) begin
          err_n = 1'b1;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      out_valid <= (state_n == HOLD);
      busy      <= (state_n == SHIFT) || (state_n == PARITY);
      frame_err <= err_n;
    end
  end

endmodule : operand_deserializer

// File: tb/tb_operand_deserializer.sv
// Directed bench for operand_deserializer: MSB-first and LSB-first WIDTH=6 plus WIDTH=1.
module tb_operand_deserializer;

  logic clk = 1'b0;
  logic reset, s_valid, s_start, s_a, s_b, out_ready;

  logic [5:0] ina6, inb6, ina6l, inb6l;
  logic [0:0] ina1, inb1;
  logic       ov6, busy6, err6, ov6l, busy6l, err6l, ov1, busy1, err1;

  int vectors     = 0;
  int miscompares = 0;
  int busy_cnt, err_cnt;

  always #5 clk = ~clk;

  operand_deserializer #(.WIDTH(6), .MSB_FIRST(1'b1)) u6 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_start(s_start), .s_a(s_a), .s_b(s_b),
    .ina(ina6), .inb(inb6), .out_valid(ov6), .out_ready(out_ready), .busy(busy6), .frame_err(err6)
  );

  operand_deserializer #(.WIDTH(6), .MSB_FIRST(1'b0)) u6l (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_start(s_start), .s_a(s_a), .s_b(s_b),
    .ina(ina6l), .inb(inb6l), .out_valid(ov6l), .out_ready(out_ready), .busy(busy6l), .frame_err(err6l)
  );

  operand_deserializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_start(s_start), .s_a(s_a), .s_b(s_b),
    .ina(ina1), .inb(inb1), .out_valid(ov1), .out_ready(out_ready), .busy(busy1), .frame_err(err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic start, input logic a, input logic b);
    s_valid = 1'b1;
    s_start = start;
    s_a     = a;
    s_b     = b;
    tick();
    s_valid = 1'b0;
    s_start = 1'b0;
  endtask

  // Sends one full frame (first character of the bit string first), plus the parity strobe
  // when parity is compiled in; counts busy and frame_err cycles seen on u6.
  task automatic send_frame(input logic [5:0] a, input logic [5:0] b);
    busy_cnt = 0;
    err_cnt  = 0;
    for (int i = 5; i >= 0; i--) begin
      s_valid = 1'b1;
      s_start = (i == 5);
      s_a     = a[i];
      s_b     = b[i];
      tick();
      busy_cnt += int'(busy6);
      err_cnt  += int'(err6);
    end
`ifdef OPERAND_PARITY_EN
    s_start = 1'b0;
    s_a     = ^a;
    s_b     = ^b;
    tick();
    busy_cnt += int'(busy6);
    err_cnt  += int'(err6);
`endif
    s_valid = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_start = 1'b0; s_a = 1'b0; s_b = 1'b0; out_ready = 1'b1;
    do_reset();
    check("reset_ina",   32'(ina6), 32'h0);
    check("reset_inb",   32'(inb6), 32'h0);
    check("reset_valid", 32'(ov6),  32'h0);
    check("reset_busy",  32'(busy6), 32'h0);
    check("reset_err",   32'(err6), 32'h0);

    // Basic frame with out_ready high.
    send_frame(6'b101101, 6'b010011);
    check("basic_valid", 32'(ov6),  32'h1);
    check("basic_ina",   32'(ina6), 32'h2D);
    check("basic_inb",   32'(inb6), 32'h13);
`ifdef OPERAND_PARITY_EN
    check("basic_busy_cycles", 32'(busy_cnt), 32'd6);
`else
    check("basic_busy_cycles", 32'(busy_cnt), 32'd5);
`endif
    check("basic_no_err", 32'(err_cnt), 32'd0);
    tick();
    check("basic_valid_one_cycle", 32'(ov6), 32'h0);

    // Back-pressure, then an s_start while holding.
    out_ready = 1'b0;
    send_frame(6'b101101, 6'b010011);
    repeat (10) tick();
    check("bp_valid_held", 32'(ov6),  32'h1);
    check("bp_ina_held",   32'(ina6), 32'h2D);
    check("bp_inb_held",   32'(inb6), 32'h13);
    strobe(1'b1, 1'b0, 1'b0);
    check("bp_start_err",  32'(err6), 32'h1);
    check("bp_start_ina",  32'(ina6), 32'h2D);
    tick();
    check("bp_err_one_cycle", 32'(err6), 32'h0);
    check("bp_still_valid",   32'(ov6),  32'h1);
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(ov6),   32'h0);
    check("bp_release_busy",  32'(busy6), 32'h0);

    // Restart: s_start on the 4th strobe of a frame.
    strobe(1'b1, 1'b0, 1'b1);
    strobe(1'b0, 1'b1, 1'b1);
    strobe(1'b0, 1'b0, 1'b1);
    send_frame(6'b111111, 6'b000001);
    check("restart_err_pulses", 32'(err_cnt), 32'd1);
    check("restart_valid",      32'(ov6),     32'h1);
    check("restart_ina",        32'(ina6),    32'h3F);
    check("restart_inb",        32'(inb6),    32'h01);
    tick();

    // Back-to-back: second s_start lands in the handshake cycle.
    send_frame(6'b101101, 6'b010011);
    check("b2b_first_valid", 32'(ov6),  32'h1);
    check("b2b_first_ina",   32'(ina6), 32'h2D);
    send_frame(6'b000111, 6'b111000);
    check("b2b_no_err", 32'(err_cnt), 32'd0);
    check("b2b_valid",  32'(ov6),     32'h1);
    check("b2b_ina",    32'(ina6),    32'h07);
    check("b2b_inb",    32'(inb6),    32'h38);
    tick();

    // LSB-first instance.
    do_reset();
    send_frame(6'b100000, 6'b000001);
    check("lsb_valid", 32'(ov6l),   32'h1);
    check("lsb_ina",   32'(ina6l),  32'h01);
    check("lsb_inb",   32'(inb6l),  32'h20);
    check("lsb_busy",  32'(busy6l), 32'h0);
    check("lsb_err",   32'(err6l),  32'h0);
    tick();

    // WIDTH = 1 instance.
    do_reset();
    check("w1_idle_valid", 32'(ov1), 32'h0);
    strobe(1'b1, 1'b1, 1'b0);
`ifdef OPERAND_PARITY_EN
    strobe(1'b0, 1'b1, 1'b0);
`endif
    check("w1_valid", 32'(ov1),   32'h1);
    check("w1_ina",   32'(ina1),  32'h1);
    check("w1_inb",   32'(inb1),  32'h0);
    check("w1_busy",  32'(busy1), 32'h0);
    check("w1_err",   32'(err1),  32'h0);
    tick();
    check("w1_handshake", 32'(ov1), 32'h0);

`ifdef OPERAND_PARITY_EN
    // Bad parity on lane A: frame discarded.
    do_reset();
    for (int i = 5; i >= 0; i--) strobe(i == 5, 1'(6'b101101 >> i), 1'b0);
    strobe(1'b0, 1'b1, 1'b0);
    check("par_bad_err",   32'(err6),  32'h1);
    check("par_bad_valid", 32'(ov6),   32'h0);
    check("par_bad_busy",  32'(busy6), 32'h0);
    tick();
    check("par_bad_err_one_cycle", 32'(err6), 32'h0);
    check("par_bad_valid_stays",   32'(ov6),  32'h0);
    send_frame(6'b101101, 6'b000000);
    check("par_good_valid", 32'(ov6),  32'h1);
    check("par_good_ina",   32'(ina6), 32'h2D);
    tick();
`endif

    // Reset in the middle of a frame.
    strobe(1'b1, 1'b1, 1'b1);
    strobe(1'b0, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b1);
    check("midrst_busy_before", 32'(busy6), 32'h1);
    reset = 1'b1;
    tick();
    check("midrst_ina",   32'(ina6),  32'h0);
    check("midrst_inb",   32'(inb6),  32'h0);
    check("midrst_valid", 32'(ov6),   32'h0);
    check("midrst_busy",  32'(busy6), 32'h0);
    check("midrst_err",   32'(err6),  32'h0);
    reset = 1'b0;
    tick();
    check("midrst_no_err_after", 32'(err6),  32'h0);
    check("midrst_idle_busy",    32'(busy6), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_operand_deserializer
